flop_pipe_chain: RTL and testbench

//   DEPTH-stage pipeline register chain with per-stage valid bits, stall, flush and occupancy count.

---
 rtl/flop_pkg.sv | 15 +
 rtl/edge_sync_detect.sv | 48 ++++
 rtl/flop_pipe_chain.sv | 110 +++++++++++
 tb/tb_flop_pipe_chain.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flop_pkg.sv
// Shared types and limits for the flop pipe chain.
// Provides the edge pacing enum and parameter bounds.
package flop_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE,
    EDGE_RISE,
    EDGE_FALL,
    EDGE_BOTH
  } edge_mode_e;

  localparam int MAX_DEPTH = 64;
  localparam int MAX_SYNC  = 4;

endpackage

// File: rtl/edge_sync_detect.sv
// Synchronises evt_src into clk, then decodes edges into a pulse.
// Ports: clk, reset_n, evt_src (async in), evt (1-cycle pulse out).
module edge_sync_detect
  import flop_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter edge_mode_e MODE        = EDGE_RISE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic evt_src,
  output logic evt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   dly_q;
  logic                   dly_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], evt_src};
    dly_d  = s;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  always_comb begin
    evt = 1'b0;
    case (MODE)
      EDGE_RISE: evt = s & ~dly_q;
      EDGE_FALL: evt = ~s & dly_q;
      EDGE_BOTH: evt = s ^ dly_q;
      default:   evt = 1'b0;
    endcase
  end

endmodule

// File: rtl/flop_pipe_chain.sv
// DEPTH-stage valid/data pipeline with stall, flush and occupancy count.
// Ports: clk, reset_n, evt_src, in_valid/in_data, stall, flush -> adv, out_valid/out_data, count.
module flop_pipe_chain
  import flop_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 2,
  parameter int EDGE_MODE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       evt_src,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       stall,
  input  logic                       flush,
  output logic                       adv,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int         CW   = $clog2(DEPTH + 1);
  localparam edge_mode_e MODE = edge_mode_e'(EDGE_MODE[1:0]);

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("flop_pipe_chain: DEPTH out of range");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > MAX_SYNC) begin : g_bad_sync
    $error("flop_pipe_chain: SYNC_STAGES out of range");
  end
  if (EDGE_MODE < 0 || EDGE_MODE > 3) begin : g_bad_mode
    $error("flop_pipe_chain: EDGE_MODE out of range");
  end

  logic evt;

  if (MODE == EDGE_NONE) begin : g_free_run
    logic unused_evt_src;
    assign unused_evt_src = evt_src;
    assign evt = 1'b1;
  end else begin : g_edge
    edge_sync_detect #(
      .SYNC_STAGES (SYNC_STAGES),
      .MODE        (MODE)
    ) u_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .evt_src (evt_src),
      .evt     (evt)
    );
  end

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  // Flush and stall swallow the event outright; nothing is queued.
  assign adv = evt & ~stall & ~flush;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    if (flush) begin
      valid_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = '0;
      end
      count_d = '0;
    end else if (adv) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        valid_d[i] = valid_q[i-1];
        data_d[i]  = data_q[i-1];
      end
      valid_d[0] = in_valid;
      data_d[0]  = in_valid ? in_data : '0;
      count_d    = count_q + CW'(in_valid)
                 - CW'(valid_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign count     = count_q;

  a_count_pop : assert property (
    @(posedge clk) disable iff (!reset_n)
    count_q == CW'($countones(valid_q))
  );

endmodule

// File: tb/tb_flop_pipe_chain.sv
// Directed bench for flop_pipe_chain: free-running, rise-paced and
// both-edge-paced instances sharing one stimulus set.
module tb_flop_pipe_chain;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       evt_src;
  logic       in_valid;
  logic [7:0] in_data;
  logic       stall;
  logic       flush;

  logic       a_adv, a_ov;
  logic [7:0] a_od;
  logic [1:0] a_cnt;
  logic       b_adv, b_ov;
  logic [7:0] b_od;
  logic [1:0] b_cnt;
  logic       c_adv, c_ov;
  logic [7:0] c_od;
  logic [1:0] c_cnt;

  always #5 clk = ~clk;

  flop_pipe_chain #(
    .WIDTH(8), .DEPTH(3), .EDGE_MODE(0), .SYNC_STAGES(2)
  ) u_a (
    .clk(clk), .reset_n(reset_n), .evt_src(evt_src),
    .in_valid(in_valid), .in_data(in_data),
    .stall(stall), .flush(flush), .adv(a_adv),
    .out_valid(a_ov), .out_data(a_od), .count(a_cnt)
  );

  flop_pipe_chain #(
    .WIDTH(8), .DEPTH(2), .EDGE_MODE(1), .SYNC_STAGES(2)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .evt_src(evt_src),
    .in_valid(in_valid), .in_data(in_data),
    .stall(stall), .flush(flush), .adv(b_adv),
    .out_valid(b_ov), .out_data(b_od), .count(b_cnt)
  );

  flop_pipe_chain #(
    .WIDTH(8), .DEPTH(2), .EDGE_MODE(3), .SYNC_STAGES(2)
  ) u_c (
    .clk(clk), .reset_n(reset_n), .evt_src(evt_src),
    .in_valid(in_valid), .in_data(in_data),
    .stall(stall), .flush(flush), .adv(c_adv),
    .out_valid(c_ov), .out_data(c_od), .count(c_cnt)
  );

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       st;
    logic       fl;
    logic       e_adv;
    logic       e_v;
    logic [7:0] e_d;
    logic [1:0] e_c;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, output int nb, output int nc);
    nb = 0;
    nc = 0;
    for (int i = 0; i < n; i++) begin
      if (b_adv) nb++;
      if (c_adv) nc++;
      tick();
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    tick();
  endtask

  vec_t tv[11];
  int   nb, nc, tb_, tc_;

  initial begin
    reset_n  = 1'b0;
    evt_src  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    stall    = 1'b0;
    flush    = 1'b0;

    //            iv  d      st  fl  adv v  data   cnt
    tv[0]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1};
    tv[1]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd2};
    tv[2]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 2'd3};
    tv[3]  = '{1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA2, 2'd2};
    tv[4]  = '{1'b1, 8'hB4, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA2, 2'd2};
    tv[5]  = '{1'b1, 8'hB5, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA3, 2'd2};
    tv[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1};
    tv[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB5, 2'd1};
    tv[8]  = '{1'b1, 8'hC8, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1};
    tv[9]  = '{1'b1, 8'hD9, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
    tv[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};

    // reset state
    #2;
    check("rst_a_ov", a_ov, 0);
    check("rst_a_od", a_od, 0);
    check("rst_a_cnt", a_cnt, 0);
    check("rst_b_adv", b_adv, 0);
    check("rst_c_cnt", c_cnt, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // free-running table
    for (int i = 0; i < 11; i++) begin
      in_valid = tv[i].iv;
      in_data  = tv[i].d;
      stall    = tv[i].st;
      flush    = tv[i].fl;
      #1;
      check($sformatf("v%0d_adv", i), a_adv, tv[i].e_adv);
      tick();
      check($sformatf("v%0d_ov", i), a_ov, tv[i].e_v);
      check($sformatf("v%0d_od", i), a_od, tv[i].e_d);
      check($sformatf("v%0d_cnt", i), a_cnt, tv[i].e_c);
    end
    in_valid = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;

    // rising-edge pacing latency
    do_reset();
    evt_src  = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick();
    check("rise_e1_adv", b_adv, 0);
    tick();
    check("rise_e2_adv", b_adv, 1);
    tick();
    check("rise_e3_adv", b_adv, 0);
    check("rise_cnt", b_cnt, 1);
    check("rise_ov", b_ov, 0);
    run(5, nb, nc);
    check("rise_hold_n", nb, 0);
    evt_src = 1'b0;
    run(6, nb, nc);
    check("rise_fall_ign", nb, 0);
    in_data = 8'h56;
    evt_src = 1'b1;
    run(6, nb, nc);
    check("rise2_n", nb, 1);
    check("rise2_cnt", b_cnt, 2);
    check("rise2_ov", b_ov, 1);
    check("rise2_od", b_od, 8'h55);

    // both-edge pacing
    evt_src = 1'b0;
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'h31;
    evt_src  = 1'b1;
    run(10, tb_, tc_);
    check("both_r_cnt", c_cnt, 1);
    in_data = 8'h32;
    evt_src = 1'b0;
    run(10, nb, nc);
    check("both_n", tc_ + nc, 2);
    check("both_cnt", c_cnt, 2);
    check("both_ov", c_ov, 1);
    check("both_od", c_od, 8'h31);

    // stall drops events
    stall   = 1'b1;
    in_data = 8'h40;
    evt_src = 1'b1;
    run(10, tb_, tc_);
    evt_src = 1'b0;
    run(10, nb, nc);
    check("stall_n", tc_ + nc, 0);
    check("stall_cnt", c_cnt, 2);
    check("stall_od", c_od, 8'h31);
    stall = 1'b0;
    run(5, nb, nc);
    check("stall_nodefer", nc, 0);
    check("stall_od2", c_od, 8'h31);

    // flush + stall + event together
    evt_src = 1'b1;
    tick();
    tick();
    check("fl_pre_adv", c_adv, 1);
    flush = 1'b1;
    stall = 1'b1;
    #1;
    check("fl_adv", c_adv, 0);
    tick();
    check("fl_ov", c_ov, 0);
    check("fl_od", c_od, 0);
    check("fl_cnt", c_cnt, 0);
    flush = 1'b0;
    stall = 1'b0;
    run(8, nb, nc);
    check("fl_consumed", nc, 0);
    check("fl_cnt2", c_cnt, 0);

    // async reset mid-stream, evt_src high through release
    in_data = 8'h61;
    evt_src = 1'b0;
    run(5, nb, nc);
    in_data = 8'h62;
    evt_src = 1'b1;
    run(5, nb, nc);
    check("ar_pre_cnt", c_cnt, 2);
    check("ar_pre_od", c_od, 8'h61);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_ov", c_ov, 0);
    check("ar_od", c_od, 0);
    check("ar_cnt", c_cnt, 0);
    check("ar_a_cnt", a_cnt, 0);
    tick();
    tick();
    reset_n  = 1'b1;
    in_data  = 8'h66;
    tick();
    check("rel_e1_adv", b_adv, 0);
    tick();
    check("rel_e2_badv", b_adv, 1);
    check("rel_e2_cadv", c_adv, 1);
    tick();
    check("rel_e3_badv", b_adv, 0);
    check("rel_b_cnt", b_cnt, 1);
    check("rel_c_cnt", c_cnt, 1);
    run(5, nb, nc);
    check("rel_once", nb, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
